// File: rtl/spi_cmd_queue.sv
// -----------------------------------------------------------------------------
// spi_cmd_queue
//
// Buffers 32-bit command words arriving from the SPI receiver and replays them,
// one at a time, to the system controller. Ordinary words are presented on
// cmd_data for a setup interval, latched with a one-cycle latch_data strobe,
// and then held for a gap interval. Words whose top nibble equals
// TRIGGER_OPCODE are presented the same way but fire a one-cycle
// control_trigger strobe. The queue then waits for cycle_done before it holds
// the gap. The head entry leaves the FIFO only when its gap completes, so
// fifo_count always includes the word in progress.
//
// Ports
//   clock           system clock; all logic runs on its rising edge
//   reset_n         asynchronous active-low reset
//   word_in         command word from the SPI receiver
//   word_valid      one-cycle push strobe for word_in
//   flush           synchronous clear of FIFO contents and sequencer
//   clear_overflow  synchronous clear of the sticky overflow flag
//   cycle_done      update-cycle-complete indication (ends a trigger wait)
//   cmd_data        registered command word presented to the controller
//   latch_data      one-cycle latch strobe for ordinary words
//   control_trigger one-cycle strobe for trigger words
//   fifo_count      number of stored words, 0..DEPTH
//   fifo_empty      fifo_count == 0
//   fifo_full       fifo_count == DEPTH
//   overflow        sticky: a push arrived while full and was dropped
//   busy            sequencer is not idle
// -----------------------------------------------------------------------------
module spi_cmd_queue #(
    parameter int          DEPTH          = 8,
    parameter int          ADDR_W         = 3,
    parameter int          SETUP_CYCLES   = 2,
    parameter int          GAP_CYCLES     = 2,
    parameter logic [3:0]  TRIGGER_OPCODE = 4'hF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       word_in,
    input  logic              word_valid,
    input  logic              flush,
    input  logic              clear_overflow,
    input  logic              cycle_done,
    output logic [31:0]       cmd_data,
    output logic              latch_data,
    output logic              control_trigger,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              overflow,
    output logic              busy
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      SETUP_LAST = 4'(SETUP_CYCLES - 1);
    // A zero gap still spends one cycle in GAP, so both 0 and 1 end on count 0.
    localparam logic [3:0]      GAP_LAST   = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LATCH,
        ST_TRIG,
        ST_WAIT,
        ST_GAP
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic                trig_reg, trig_next;
    logic [ADDR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [ADDR_W:0]     count_reg;
    logic [31:0]         cmd_reg;
    logic                overflow_reg;

    logic [31:0]         mem [DEPTH];
    logic [3:0]          head_opcode;

    logic                pop;
    logic                load_cmd;
    logic                is_full;
    logic                push_ok;
    logic                drop;

    assign head_opcode = mem[rd_ptr_reg][31:28];
    assign is_full     = (count_reg == FULL_COUNT);

    // A full FIFO still accepts a word on the cycle the head is popped.
    assign push_ok = word_valid && !flush && (!is_full || pop);
    assign drop    = word_valid && !flush && is_full && !pop;

    // ------------------------------------------------------------------
    // Sequencer next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        trig_next  = 1'b0;
        pop        = 1'b0;
        load_cmd   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (count_reg != '0) begin
                    load_cmd = 1'b1;
                    cnt_next = 4'd0;
                    // Decide on the head entry itself: cmd_data is being
                    // loaded with exactly this word on the same edge.
                    if (head_opcode == TRIGGER_OPCODE) begin
                        state_next = ST_TRIG;
                    end else begin
                        state_next = ST_SETUP;
                    end
                end
            end

            ST_SETUP: begin
                if (cnt_reg == SETUP_LAST) begin
                    state_next = ST_LATCH;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end

            ST_LATCH: begin
                state_next = ST_GAP;
                cnt_next   = 4'd0;
            end

            ST_TRIG: begin
                // control_trigger is registered, so it is high during the
                // first WAIT cycle.
                trig_next  = 1'b1;
                state_next = ST_WAIT;
            end

            ST_WAIT: begin
                if (cycle_done) begin
                    state_next = ST_GAP;
                    cnt_next   = 4'd0;
                end
            end

            ST_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    pop        = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, pointers, count, command register and overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 4'd0;
            trig_reg     <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            cmd_reg      <= 32'd0;
            overflow_reg <= 1'b0;
        end else begin
            if (flush) begin
                state_reg  <= ST_IDLE;
                cnt_reg    <= 4'd0;
                trig_reg   <= 1'b0;
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                state_reg <= state_next;
                cnt_reg   <= cnt_next;
                trig_reg  <= trig_next;

                if (push_ok) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end

                if (push_ok && !pop) begin
                    count_reg <= count_reg + 1'b1;
                end else if (pop && !push_ok) begin
                    count_reg <= count_reg - 1'b1;
                end

                if (load_cmd) begin
                    cmd_reg <= mem[rd_ptr_reg];
                end
            end

            // Set has priority over clear so a drop is never lost.
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (clear_overflow) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // Storage array: write-only here, no reset needed on the contents.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= word_in;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all derived from registered state
    // ------------------------------------------------------------------
    assign cmd_data        = cmd_reg;
    assign latch_data      = (state_reg == ST_LATCH);
    assign control_trigger = trig_reg;
    assign fifo_count      = count_reg;
    assign fifo_empty      = (count_reg == '0);
    assign fifo_full       = is_full;
    assign overflow        = overflow_reg;
    assign busy            = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_queue
//
// Scoreboard bench for spi_cmd_queue. A reference model advances once per
// rising edge: it keeps the stored words in a queue and schedules each word's
// service with plain arithmetic (load edge, strobe edge, pop edge). When it
// starts serving a word it pushes the expected strobe (word, kind, edge) into
// a scoreboard queue; a separate monitor pops and compares whenever the DUT
// raises latch_data or control_trigger, and checks the status outputs every
// cycle against the model.
// -----------------------------------------------------------------------------
module tb_spi_cmd_queue;

    localparam int         DEPTH   = 8;
    localparam int         ADDR_W  = 3;
    localparam int         SETUP   = 2;
    localparam int         GAP     = 2;
    localparam logic [3:0] TRIG_OP = 4'hF;
    localparam int         GAPC    = (GAP == 0) ? 1 : GAP;

    logic              clock;
    logic              reset_n;
    logic [31:0]       word_in;
    logic              word_valid;
    logic              flush;
    logic              clear_overflow;
    logic              cycle_done;
    logic [31:0]       cmd_data;
    logic              latch_data;
    logic              control_trigger;
    logic [ADDR_W:0]   fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              overflow;
    logic              busy;

    spi_cmd_queue #(
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .SETUP_CYCLES   (SETUP),
        .GAP_CYCLES     (GAP),
        .TRIGGER_OPCODE (TRIG_OP)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .word_in         (word_in),
        .word_valid      (word_valid),
        .flush           (flush),
        .clear_overflow  (clear_overflow),
        .cycle_done      (cycle_done),
        .cmd_data        (cmd_data),
        .latch_data      (latch_data),
        .control_trigger (control_trigger),
        .fifo_count      (fifo_count),
        .fifo_empty      (fifo_empty),
        .fifo_full       (fifo_full),
        .overflow        (overflow),
        .busy            (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] word;
        bit          trig;
        int          edge_no;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mq[$];
    int          edge_n      = 0;
    bit          m_busy      = 0;
    bit          m_trig      = 0;
    int          m_pop_edge  = -1;
    int          m_wait_from = 0;
    logic [31:0] m_cmd       = 32'd0;
    bit          m_ovf       = 0;

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_busy     = 0;
        m_trig     = 0;
        m_pop_edge = -1;
        m_cmd      = 32'd0;
        m_ovf      = 0;
    endtask

    task automatic model_step(input int n);
        int   pre;
        bit   was_idle;
        bit   pop_now;
        bit   accept;
        exp_t keep[$];
        exp_t e;
        pre      = mq.size();
        was_idle = !m_busy;
        pop_now  = m_busy && (m_pop_edge == n);
        if (flush) begin
            mq.delete();
            m_busy     = 0;
            m_pop_edge = -1;
            foreach (exp_q[i]) if (exp_q[i].edge_no < n) keep.push_back(exp_q[i]);
            exp_q = keep;
            if (clear_overflow) m_ovf = 0;
            return;
        end
        accept = word_valid && (pre < DEPTH || pop_now);
        if (pop_now) begin
            void'(mq.pop_front());
            m_busy = 0;
        end
        if (accept) mq.push_back(word_in);
        if (word_valid && !accept) m_ovf = 1;
        else if (clear_overflow)   m_ovf = 0;

        if (was_idle && pre > 0) begin
            m_cmd  = mq[0];
            m_busy = 1;
            e.word = m_cmd;
            if (m_cmd[31:28] == TRIG_OP) begin
                m_trig      = 1;
                m_pop_edge  = -1;
                m_wait_from = n + 2;
                e.trig      = 1;
                e.edge_no   = n + 1;
            end else begin
                m_trig     = 0;
                m_pop_edge = n + SETUP + 1 + GAPC;
                e.trig     = 0;
                e.edge_no  = n + SETUP;
            end
            exp_q.push_back(e);
        end else if (m_busy && m_trig && m_pop_edge < 0 && n >= m_wait_from && cycle_done) begin
            m_pop_edge = n + GAPC;
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            edge_n++;
            if (!reset_n) model_reset();
            else          model_step(edge_n);
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
            chk("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
            chk("fifo_full",  32'(fifo_full),  32'(mq.size() == DEPTH));
            chk("overflow",   32'(overflow),   32'(m_ovf));
            chk("busy",       32'(busy),       32'(m_busy));
            chk("cmd_data",   cmd_data,        m_cmd);
            if (latch_data && control_trigger) begin
                checks++;
                errors++;
                $display("FAIL strobe_exclusive latch=1 trigger=1 required one of them 0");
            end else if (latch_data || control_trigger) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe edge=%0d cmd=%h required no strobe", edge_n, cmd_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_word", cmd_data, e.word);
                    chk("strobe_kind", 32'(control_trigger), 32'(e.trig));
                    chk("strobe_edge", 32'(edge_n), 32'(e.edge_no));
                    $display("strobe %s word=%h edge=%0d", control_trigger ? "trig " : "latch", cmd_data, edge_n);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int cd_mode = 0;   // 0 random, 1 forced low, 2 forced high

    task automatic cyc(input bit v, input logic [31:0] d, input bit f, input bit c);
        word_valid     = v;
        word_in        = d;
        flush          = f;
        clear_overflow = c;
        case (cd_mode)
            0:       cycle_done = ($urandom_range(0, 3) == 0);
            1:       cycle_done = 1'b0;
            default: cycle_done = 1'b1;
        endcase
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 32'd0, 0, 0);
    endtask

    task automatic wait_idle(input string name);
        int i;
        cd_mode = 0;
        i = 0;
        while (!(mq.size() == 0 && !m_busy) && i < 600) begin
            cyc(0, 32'd0, 0, 0);
            i++;
        end
        chk(name, 32'(mq.size() == 0 && !m_busy), 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        reset_n        = 1'b0;
        word_in        = 32'd0;
        word_valid     = 1'b0;
        flush          = 1'b0;
        clear_overflow = 1'b0;
        cycle_done     = 1'b0;
        repeat (3) @(negedge clock);

        chk("rst_cmd_data",  cmd_data,               32'd0);
        chk("rst_latch",     32'(latch_data),        32'd0);
        chk("rst_trigger",   32'(control_trigger),   32'd0);
        chk("rst_count",     32'(fifo_count),        32'd0);
        chk("rst_empty",     32'(fifo_empty),        32'd1);
        chk("rst_full",      32'(fifo_full),         32'd0);
        chk("rst_overflow",  32'(overflow),          32'd0);
        chk("rst_busy",      32'(busy),              32'd0);
        reset_n = 1'b1;

        // Single normal word
        cyc(1, 32'h1234_5678, 0, 0);
        chk("single_count_after_push", 32'(fifo_count), 32'd1);
        wait_idle("single_drain");

        // Trigger word held in WAIT for 50 cycles
        cd_mode = 1;
        cyc(1, 32'hF000_0000, 0, 0);
        idle(50);
        chk("trig_hold_busy",  32'(busy),       32'd1);
        chk("trig_hold_count", 32'(fifo_count), 32'd1);
        cd_mode = 2;
        idle(1);
        cd_mode = 1;
        idle(GAPC + 2);
        chk("trig_released_count", 32'(fifo_count), 32'd0);
        wait_idle("trig_drain");

        // Fill and overflow behind a pending trigger word
        cd_mode = 1;
        cyc(1, 32'hF000_0001, 0, 0);
        for (int i = 1; i < 9; i++) cyc(1, 32'h0000_A000 + 32'(i), 0, 0);
        chk("fill_full",     32'(fifo_full), 32'd1);
        chk("fill_overflow", 32'(overflow),  32'd1);
        idle(3);
        cyc(0, 32'd0, 0, 1);
        chk("overflow_cleared", 32'(overflow), 32'd0);
        wait_idle("fill_drain");

        // Full FIFO with a push on the pop edge
        cd_mode = 1;
        cyc(1, 32'hF000_0002, 0, 0);
        for (int i = 1; i < 8; i++) cyc(1, 32'h0000_B000 + 32'(i), 0, 0);
        idle(5);
        cd_mode = 2;
        idle(1);
        cd_mode = 1;
        idle(GAPC - 1);
        cyc(1, 32'h0000_B0FF, 0, 0);
        chk("simul_count",    32'(fifo_count), 32'd8);
        chk("simul_overflow", 32'(overflow),   32'd0);
        wait_idle("simul_drain");

        // Pointer wrap with 20 incrementing words
        for (int i = 0; i < 20; i++) begin
            cyc(1, 32'h0000_0100 + 32'(i), 0, 0);
            idle(5);
        end
        wait_idle("wrap_drain");

        // Flush during WAIT, with a push on the flush cycle
        cd_mode = 1;
        cyc(1, 32'hF0AB_CDEF, 0, 0);
        idle(10);
        cyc(1, 32'h1111_1111, 1, 0);
        chk("flush_busy",     32'(busy),       32'd0);
        chk("flush_count",    32'(fifo_count), 32'd0);
        chk("flush_cmd",      cmd_data,        32'hF0AB_CDEF);
        chk("flush_overflow", 32'(overflow),   32'd0);
        wait_idle("flush_drain");

        // Asynchronous reset in SETUP
        cyc(1, 32'h0ABC_0001, 0, 0);
        idle(2);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_cmd",     cmd_data,             32'd0);
        chk("arst_latch",   32'(latch_data),      32'd0);
        chk("arst_trigger", 32'(control_trigger), 32'd0);
        chk("arst_count",   32'(fifo_count),      32'd0);
        chk("arst_empty",   32'(fifo_empty),      32'd1);
        chk("arst_busy",    32'(busy),            32'd0);
        @(negedge clock);
        idle(2);
        reset_n = 1'b1;
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            d = $urandom;
            if ($urandom_range(0, 7) != 0) d[31:28] = 4'($urandom_range(0, 14));
            cyc($urandom_range(0, 2) == 0, d, $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0);
        end
        wait_idle("random_drain");
        idle(2);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
